instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Front end for the accumulator/stack processor: fetches 16-bit instruction words from instruction memory over a req/ack handshake.
- Buffers fetched words in a small FIFO and presents OPCODE, flagbit and immediate to control_unit with a valid/take handshake.
- Accepts PC redirects for JIMM/JACC/JCMP/JFNC: flushes buffered and in-flight fetches, then restarts at the new PC.

Parameters:
- PC_W, 16, width of PC and instruction address (byte address).
- DEPTH, 2, instruction buffer entries (power of 2, >=2).
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  PC_W  fetch address; stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  in  16  instruction word.
- instr_valid  out  1  buffer head valid.
- instr_take  in  1  control_unit consumes head (ignored when instr_valid=0).
- OPCODE  out  5  head[15:11].
- flagbit  out  1  head[10].
- imm  out  10  head[9:0].
- instr_pc  out  PC_W  address of head instruction.
- redirect_valid  in  1  one-cycle PC redirect.
- redirect_pc  in  PC_W  new fetch address (bit 0 forced to 0).

Behaviour:
- Reset (Reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty.
  - imem_req=0, instr_valid=0, OPCODE=0, flagbit=0, imm=0, instr_pc=0, drop=0.
  - imem_req falls immediately, even mid-request.
- FSM states:
  - IDLE: entered from reset; lasts one cycle, then goes to REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On imem_ack with drop=0: push {fetch_pc, imem_rdata}; fetch_pc += 2.
    - On imem_ack with drop=1: discard the word and clear drop.
    - After an ack, go to REQ if space remains after this cycle's push/pop, else STALL.
  - STALL: imem_req=0; go to REQ the cycle after occupancy < DEPTH.
- At most one outstanding request. A request is issued only when the FIFO is not full, so an ack always has a free slot.
- Issue:
  - Outputs are combinational from the FIFO head; instr_valid = (count != 0).
  - Push into an empty FIFO: instr_valid=1 in the cycle after the ack (1-cycle fetch-to-issue latency).
  - Pop on instr_take & instr_valid.
  - Simultaneous push and pop: count unchanged, order preserved.
- Redirect:
  - On redirect_valid: FIFO cleared (instr_valid=0 next cycle); fetch_pc=redirect_pc.
  - Overrides a same-cycle push, pop or ack.
  - If a request is outstanding and not acked this cycle: drop=1, imem_req stays high with the old address until the ack. A new request to redirect_pc is issued in the cycle after that ack.
  - If no request is outstanding, or an ack arrives in the redirect cycle: the next cycle requests redirect_pc.
  - A second redirect while drop=1 only updates fetch_pc.
- PC arithmetic wraps modulo 2^PC_W (16'hFFFE + 2 = 16'h0000).
- instr_take with instr_valid=0 has no effect.

Decomposition:
- Shared package (cpu_pkg): opcode field positions (OP_MSB=15, OP_LSB=11, FLAG_BIT=10, IMM_W=10), opcode constants (APUT=5'b00000 … SWAP=5'b10111) and FSM state encodings (IDLE, REQ, STALL). The same constants are used by control_unit.
- One sub-module: instr_fifo (DEPTH x (PC_W+16), push/pop/flush, count, head outputs).

Test Plan:
- Reset release, memory acks after 1 cycle with 16'h0C00 at 0x0000 -> imem_addr=0x0000; instr_valid=1 one cycle after the ack; OPCODE=5'b00001 (SPUT), flagbit=1, imm=0, instr_pc=0.
- instr_take held 0, memory acks every request -> exactly 2 pushes (0x0000, 0x0002), then imem_req=0 (STALL). One take -> request 0x0004 reissued the next cycle.
- Ack 3 cycles late; redirect_pc=0x0100 asserted mid-wait -> stale word discarded, next imem_addr=0x0100, instr_valid stays 0 until the 0x0100 word arrives.
- Redirect in the same cycle as ack and take with FIFO holding 1 entry -> FIFO empty next cycle, ack data not pushed, next request at redirect_pc.
- fetch_pc=16'hFFFE, ack -> instr_pc=16'hFFFE, next imem_addr=16'h0000.
- Reset asserted while imem_req=1 -> imem_req=0 and instr_valid=0 before the next CLK edge; first request after release at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator/stack processor front end and control unit:
// instruction field positions, opcode codes and the fetch FSM encoding.
package cpu_pkg;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 11;
  localparam int FLAG_BIT = 10;
  localparam int IMM_W    = 10;
  localparam int OP_W     = OP_MSB - OP_LSB + 1;

  typedef enum logic [OP_W-1:0] {
    APUT = 5'b00000,
    SPUT = 5'b00001,
    SWAP = 5'b10111
  } opcodeT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2
  } fetchStateT;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory, issue and redirect handshakes.
// master = fetch unit, slave = memory/control side.
interface instr_fetch_unit_if #(
  parameter int PC_W = 16
);
  import cpu_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  logic            instr_valid;
  logic            instr_take;
  logic [OP_W-1:0] OPCODE;
  logic            flagbit;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0] instr_pc;

  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, OPCODE, flagbit, imm, instr_pc,
    input  imem_ack, imem_rdata, instr_take, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, OPCODE, flagbit, imm, instr_pc,
    output imem_ack, imem_rdata, instr_take, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_fifo.sv
// Small power-of-two instruction buffer with push/pop/flush; head outputs read zero when empty.
module instr_fifo #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wrData,
  output logic [CNT_W-1:0] count,
  output logic             headValid,
  output logic [WIDTH-1:0] headData
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPop;

  assign headValid = (count != '0);
  assign doPop     = pop && headValid;
  assign headData  = headValid ? mem[rdPtr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push)  wrPtr <= wrPtr + PTR_W'(1);
      if (doPop) rdPtr <= rdPtr + PTR_W'(1);
      if (push && !doPop)      count <= count + CNT_W'(1);
      else if (doPop && !push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: storage is not reset; headValid masks stale entries, so a reset here only costs flops.
  always_ff @(posedge CLK) begin
    if (push && !flush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, DEPTH-entry buffer,
// and PC redirect with discard of a stale in-flight word.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                Reset,
  instr_fetch_unit_if.master  bus
);

  localparam int               CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetchStateT       state;
  logic             drop;
  logic             reqQ;
  logic [PC_W-1:0]  fetchPc;
  logic [PC_W-1:0]  addrQ;

  logic             push;
  logic             pop;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic             spaceNext;
  logic             headValid;
  logic [PC_W+15:0] headData;
  logic [PC_W-1:0]  targetPc;
  logic [PC_W-1:0]  ackPc;

  assign flush    = bus.redirect_valid;
  assign push     = (state == REQ) && bus.imem_ack && !drop && !flush;
  assign pop      = bus.instr_take && headValid && !flush;
  assign targetPc = {bus.redirect_pc[PC_W-1:1], 1'b0};
  // A discarded ack leaves fetchPc on the redirect target; a real ack advances it.
  assign ackPc    = drop ? fetchPc : fetchPc + PC_W'(2);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    countNext = count;
    if (flush)               countNext = '0;
    else if (push && !pop)   countNext = count + CNT_W'(1);
    else if (pop && !push)   countNext = count - CNT_W'(1);
  end

  assign spaceNext = (countNext < DEPTH_C);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      drop    <= 1'b0;
      reqQ    <= 1'b0;
      fetchPc <= RESET_PC;
      addrQ   <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          reqQ  <= 1'b1;
          if (flush) begin
            fetchPc <= targetPc;
            addrQ   <= targetPc;
          end else begin
            addrQ <= fetchPc;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            drop <= 1'b0;
            if (flush) begin
              fetchPc <= targetPc;
              addrQ   <= targetPc;
            end else begin
              fetchPc <= ackPc;
              addrQ   <= ackPc;
              state   <= spaceNext ? REQ : STALL;
              reqQ    <= spaceNext;
            end
          end else if (flush) begin
            // Request already on the bus: keep it stable, discard its word later.
            fetchPc <= targetPc;
            drop    <= 1'b1;
          end
        end
        STALL: begin
          if (flush) begin
            fetchPc <= targetPc;
            addrQ   <= targetPc;
            state   <= REQ;
            reqQ    <= 1'b1;
          end else if (spaceNext) begin
            addrQ <= fetchPc;
            state <= REQ;
            reqQ  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          reqQ  <= 1'b0;
        end
      endcase
    end
  end

  instr_fifo #(
    .WIDTH (PC_W + 16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .Reset     (Reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wrData    ({fetchPc, bus.imem_rdata}),
    .count     (count),
    .headValid (headValid),
    .headData  (headData)
  );

  assign bus.imem_req    = reqQ;
  assign bus.imem_addr   = addrQ;
  assign bus.instr_valid = headValid;
  assign bus.OPCODE      = headData[OP_MSB:OP_LSB];
  assign bus.flagbit     = headData[FLAG_BIT];
  assign bus.imm         = headData[IMM_W-1:0];
  assign bus.instr_pc    = headData[PC_W+15:16];

endmodule
